// File: rtl/apb_arb_pkg.sv
// Shared definitions for the APB requester arbiter: FSM encoding,
// default widths and the grant-index width helper.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_AW      = 8;
    localparam int DEF_DW      = 8;
    localparam int DEF_TIMEOUT = 15;

    // Width of a requester index; never below one bit so ports stay legal.
    function automatic int gnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts at ptr, wraps
// around, and the first eligible requester in rotated order wins.
module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int GW   = gnt_w(NREQ)
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [GW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [GW-1:0]   idx,
    output logic            any_valid
);

    localparam logic [GW:0] N_W = (GW+1)'(NREQ);

    logic [GW:0] pos;

    // Rotated priority search starting at the round-robin pointer.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value held, which would infer a latch.
        grant     = '0;
        idx       = '0;
        any_valid = 1'b0;
        pos       = '0;
        for (int off = 0; off < NREQ; off++) begin
            pos = {1'b0, ptr} + (GW+1)'(off);
            if (pos >= N_W) pos = pos - N_W;
            if (!any_valid && eligible[pos[GW-1:0]]) begin
                any_valid            = 1'b1;
                grant[pos[GW-1:0]]   = 1'b1;
                idx                  = pos[GW-1:0];
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master port between NREQ local requesters. Round-robin
// grant in IDLE, one SETUP cycle, then ACCESS until pready or timeout;
// the served requester gets a one-cycle ack (with err on timeout).
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter  int NREQ    = DEF_NREQ,
    parameter  int AW      = DEF_AW,
    parameter  int DW      = DEF_DW,
    parameter  int TIMEOUT = DEF_TIMEOUT,
    localparam int GW      = gnt_w(NREQ)
) (
    input  logic               clk,
    input  logic               prst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    wr,
    input  logic [NREQ*AW-1:0] addr_p,
    input  logic [NREQ*DW-1:0] data_p,
    output logic [NREQ-1:0]    ack,
    output logic               err,
    output logic [DW-1:0]      rdata,
    output logic [GW-1:0]      gnt_id,
    output logic               psel,
    output logic               penable,
    output logic               pwrite,
    output logic [AW-1:0]      paddr,
    output logic [DW-1:0]      pwdata,
    input  logic [DW-1:0]      prdata,
    input  logic               pready
);

    // Last pready-low ACCESS cycle allowed; the abort happens on it.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t          state;
    logic [GW-1:0]   ptr;
    logic [7:0]      wait_cnt;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] win_oh;
    logic [GW-1:0]   win_idx;
    logic            any_valid;
    logic            sel_wr;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic [GW-1:0]   next_ptr;

    // A requester still seeing its ack has not yet dropped req; skip it.
    assign eligible = req & ~ack;

    assign next_ptr = (gnt_id == GW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

    rr_arbiter #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_rr (
        .eligible  (eligible),
        .ptr       (ptr),
        .grant     (win_oh),
        .idx       (win_idx),
        .any_valid (any_valid)
    );

    // One-hot AND-OR mux of the winning requester's transfer fields.
    always_comb begin
        sel_wr   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                sel_wr   = sel_wr   | wr[i];
                sel_addr = sel_addr | addr_p[i*AW +: AW];
                sel_data = sel_data | data_p[i*DW +: DW];
            end
        end
    end

    // Transfer sequencer with registered APB, grant and completion outputs.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (prst) begin
            state    <= IDLE;
            ptr      <= '0;
            wait_cnt <= '0;
            ack      <= '0;
            err      <= 1'b0;
            rdata    <= '0;
            gnt_id   <= '0;
            psel     <= 1'b0;
            penable  <= 1'b0;
            pwrite   <= 1'b0;
            paddr    <= '0;
            pwdata   <= '0;
        end else begin
            ack   <= '0;
            err   <= 1'b0;
            rdata <= '0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        pwrite   <= sel_wr;
                        paddr    <= sel_addr;
                        pwdata   <= sel_data;
                        gnt_id   <= win_idx;
                        psel     <= 1'b1;
                        penable  <= 1'b0;
                        wait_cnt <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        if (!pwrite) rdata <= prdata;
                        ack[gnt_id] <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        ptr         <= next_ptr;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt == TO_LAST) begin
                            ack[gnt_id] <= 1'b1;
                            err         <= 1'b1;
                            psel        <= 1'b0;
                            penable     <= 1'b0;
                            ptr         <= next_ptr;
                            state       <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Randomized bench for apb_req_arbiter. A transaction-level model picks
// the round-robin winner, plans each transfer's wait states (acting as the
// APB slave), and predicts every output cycle from the latency rules.
module tb_apb_req_arbiter;
    import apb_arb_pkg::*;

    localparam int NREQ    = 4;
    localparam int AW      = 8;
    localparam int DW      = 8;
    localparam int TIMEOUT = 15;
    localparam int GW      = 2;
    localparam int N_CYC   = 4000;

    logic               clk;
    logic               prst;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    wr;
    logic [NREQ*AW-1:0] addr_p;
    logic [NREQ*DW-1:0] data_p;
    logic [NREQ-1:0]    ack;
    logic               err;
    logic [DW-1:0]      rdata;
    logic [GW-1:0]      gnt_id;
    logic               psel;
    logic               penable;
    logic               pwrite;
    logic [AW-1:0]      paddr;
    logic [DW-1:0]      pwdata;
    logic [DW-1:0]      prdata;
    logic               pready;

    apb_req_arbiter #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .prst    (prst),
        .req     (req),
        .wr      (wr),
        .addr_p  (addr_p),
        .data_p  (data_p),
        .ack     (ack),
        .err     (err),
        .rdata   (rdata),
        .gnt_id  (gnt_id),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Slave memory and requester-side state.
    logic [DW-1:0] mem [256];
    bit            r_req  [NREQ];
    bit            r_wr   [NREQ];
    logic [AW-1:0] r_addr [NREQ];
    logic [DW-1:0] r_data [NREQ];

    // Transaction model: one transfer in flight at most.
    int            e;            // number of the most recent edge
    bit            m_busy;
    int            m_g;          // edge at which the grant was taken
    int            m_id;
    bit            m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_w;          // planned pready-low ACCESS cycles
    int            m_ptr;
    int            phase;
    bit            force_rst;

    // Expected outputs for the cycle after edge e.
    bit            e_psel, e_pen, e_pwrite, e_err;
    logic [AW-1:0] e_paddr;
    logic [DW-1:0] e_pwdata, e_rdata;
    logic [NREQ-1:0] e_ack;
    int            e_gnt;

    function automatic int pick_wait();
        int r;
        if (phase == 2) begin
            r = $urandom_range(0, 5);
            case (r)
                0: return 0;
                1: return 1;
                2: return 14;
                3: return 15;
                default: return 20;
            endcase
        end
        r = $urandom_range(0, 19);
        if (r < 8)  return 0;
        if (r < 12) return 1;
        if (r < 15) return 2;
        if (r < 17) return 3;
        if (r == 17) return 14;
        if (r == 18) return 15;
        return 25;
    endfunction

    task automatic new_fields(input int i);
        r_wr[i]   = bit'($urandom_range(0, 1));
        r_addr[i] = ($urandom_range(0, 3) == 0) ? 8'h10 : AW'($urandom_range(0, 15));
        r_data[i] = DW'($urandom);
    endtask

    task automatic drive_inputs();
        int  nxt;
        bit  granted;
        bit  rdy;
        logic [NREQ-1:0] pmask;
        nxt   = e + 1;
        pmask = (phase == 0) ? 4'b0101 : 4'b1111;

        if (cyc < 2)                                       prst = 1'b1;
        else if (force_rst && m_busy && nxt >= m_g + 3) begin
            prst      = 1'b1;
            force_rst = 1'b0;
        end else                                           prst = ($urandom_range(0, 399) == 0);

        for (int i = 0; i < NREQ; i++) begin
            granted = m_busy && (m_id == i);
            if (!pmask[i]) begin
                r_req[i] = 1'b0;
            end else if (e_ack[i]) begin
                if (phase == 0 || $urandom_range(0, 1) == 1) begin
                    r_req[i] = 1'b1;
                    new_fields(i);
                end else begin
                    r_req[i] = 1'b0;
                end
            end else if (!r_req[i]) begin
                if (phase == 0 || $urandom_range(0, 3) == 0) begin
                    r_req[i] = 1'b1;
                    new_fields(i);
                end
            end else if (granted) begin
                if ($urandom_range(0, 3) == 0)  new_fields(i);
                if ($urandom_range(0, 15) == 0) r_req[i] = 1'b0;
            end else begin
                if (phase != 0 && $urandom_range(0, 31) == 0) r_req[i] = 1'b0;
                else if ($urandom_range(0, 7) == 0)          new_fields(i);
            end
            req[i]              = r_req[i];
            wr[i]               = r_wr[i];
            addr_p[i*AW +: AW]  = r_addr[i];
            data_p[i*DW +: DW]  = r_data[i];
        end

        // Slave behaviour follows the planned wait count of the transfer.
        rdy = m_busy && (m_w < TIMEOUT) && (nxt == m_g + 2 + m_w);
        if (m_busy && nxt >= m_g + 2) pready = rdy;
        else                          pready = bit'($urandom_range(0, 1));
        prdata = rdy ? mem[m_addr] : DW'($urandom);
    endtask

    task automatic model_step();
        logic [NREQ-1:0] elig;
        bit done, to;
        int i;
        e++;
        elig    = req & ~e_ack;
        e_ack   = '0;
        e_err   = 1'b0;
        e_rdata = '0;
        if (prst) begin
            m_busy = 1'b0; m_ptr = 0;
            e_psel = 1'b0; e_pen = 1'b0; e_pwrite = 1'b0;
            e_paddr = '0; e_pwdata = '0; e_gnt = 0;
        end else if (m_busy) begin
            if (e == m_g + 1) begin
                e_pen = 1'b1;
            end else begin
                done = 1'b0; to = 1'b0;
                if (m_w < TIMEOUT && e == m_g + 2 + m_w) done = 1'b1;
                else if (m_w >= TIMEOUT && e == m_g + 1 + TIMEOUT) begin
                    done = 1'b1; to = 1'b1;
                end
                if (done) begin
                    e_ack[m_id] = 1'b1;
                    e_err       = to;
                    if (!to && !m_wr) e_rdata      = mem[m_addr];
                    if (!to && m_wr)  mem[m_addr]  = m_data;
                    e_psel = 1'b0; e_pen = 1'b0;
                    m_ptr  = (m_id + 1) % NREQ;
                    m_busy = 1'b0;
                end
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                i = (m_ptr + k) % NREQ;
                if (!m_busy && elig[i]) begin
                    m_busy = 1'b1; m_g = e; m_id = i;
                    m_wr = r_wr[i]; m_addr = r_addr[i]; m_data = r_data[i];
                    m_w  = pick_wait();
                    e_psel = 1'b1; e_pen = 1'b0; e_gnt = i;
                    e_pwrite = m_wr; e_paddr = m_addr; e_pwdata = m_data;
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("psel",    psel,    e_psel);
        check("penable", penable, e_pen);
        check("pwrite",  pwrite,  e_pwrite);
        check("paddr",   paddr,   e_paddr);
        check("pwdata",  pwdata,  e_pwdata);
        check("gnt_id",  gnt_id,  e_gnt);
        check("ack",     ack,     e_ack);
        check("err",     err,     e_err);
        check("rdata",   rdata,   e_rdata);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = DW'($urandom);
        for (int i = 0; i < NREQ; i++) begin
            r_req[i] = 1'b0; r_wr[i] = 1'b0; r_addr[i] = '0; r_data[i] = '0;
        end
        prst = 1'b1; req = '0; wr = '0; addr_p = '0; data_p = '0;
        pready = 1'b0; prdata = '0;
        e = 0; m_busy = 1'b0; m_g = 0; m_id = 0; m_wr = 1'b0; m_addr = '0;
        m_data = '0; m_w = 0; m_ptr = 0; phase = 0; force_rst = 1'b0;
        e_ack = '0; e_gnt = 0;
        model_step();
        for (int c = 0; c < N_CYC; c++) begin
            @(negedge clk);
            cyc = c;
            check_outputs();
            if (c == 500 || c == 1000 || c == 2000 || c == 3000) force_rst = 1'b1;
            phase = (c < 1000) ? 0 : (c < 3000) ? 1 : 2;
            drive_inputs();
            model_step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
